// File: rtl/if_id_ctrl_pkg.sv
// rtl/if_id_ctrl_pkg.sv - shared widths, defaults, FSM encoding and helpers for the fetch controller
package if_id_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_perf_cnt.sv
// rtl/if_id_perf_cnt.sv - saturating fetch/stall/drop event counters
module if_id_perf_cnt
  import if_id_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch,
  input  logic        i_stall,
  input  logic        i_drop,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_drop_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (i_fetch) r_fetch_cnt <= sat_inc(r_fetch_cnt);
      if (i_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (i_drop)  r_drop_cnt  <= sat_inc(r_drop_cnt);
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: rtl/if_id_ctrl.sv
// rtl/if_id_ctrl.sv - fetch sequencer driving the IF/ID register write port
// Optional perf counters enabled by IF_ID_PERF_CNT_EN.
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned          DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [DATA_W-1:0]    NOP_INST = DATA_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
`ifdef IF_ID_PERF_CNT_EN
  output logic [DATA_W-1:0] reg_data_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       drop_cnt_o
`else
  output logic [DATA_W-1:0] reg_data_o
`endif
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_drop;
  logic              r_id_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;

  fetch_state_e      w_state_n;
  logic [ADDR_W-1:0] w_pc_n;
  logic              w_drop_n;
  logic              w_id_valid_n;
  logic [ADDR_W-1:0] w_buf_addr_n;
  logic [DATA_W-1:0] w_buf_data_n;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_real_wr;
  logic              w_discard;
  logic              w_slot_free;
  logic              w_outstanding;

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_drop_n      = r_drop;
    w_id_valid_n  = r_id_valid;
    w_buf_addr_n  = r_buf_addr;
    w_buf_data_n  = r_buf_data;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;
    w_real_wr     = 1'b0;
    w_discard     = 1'b0;
    w_slot_free   = !r_id_valid || id_ready_i;
    w_outstanding = ((r_state == ST_WAIT) && !imem_rvalid_i) ||
                    ((r_state == ST_REQ) && imem_gnt_i);

    if (r_id_valid && id_ready_i) w_id_valid_n = 1'b0;

    unique case (r_state)
      ST_IDLE: w_state_n = ST_REQ;
      ST_REQ: begin
        if (imem_gnt_i) w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (r_drop) begin
            w_discard = 1'b1;
            w_drop_n  = 1'b0;
            w_state_n = ST_REQ;
          end else if (w_slot_free) begin
            w_we         = 1'b1;
            w_real_wr    = 1'b1;
            w_waddr      = r_pc;
            w_wdata      = imem_rdata_i;
            w_id_valid_n = 1'b1;
            w_pc_n       = r_pc + ADDR_W'(4);
            w_state_n    = ST_REQ;
          end else begin
            w_buf_addr_n = r_pc;
            w_buf_data_n = imem_rdata_i;
            w_pc_n       = r_pc + ADDR_W'(4);
            w_state_n    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (id_ready_i) begin
          w_we         = 1'b1;
          w_real_wr    = 1'b1;
          w_waddr      = r_buf_addr;
          w_wdata      = r_buf_data;
          w_id_valid_n = 1'b1;
          w_state_n    = ST_REQ;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // A response landing in the redirect cycle is consumed here, so only a still-open request arms the drop.
    if (redirect_valid_i) begin
      w_we         = 1'b1;
      w_real_wr    = 1'b0;
      w_waddr      = '0;
      w_wdata      = NOP_INST;
      w_id_valid_n = 1'b0;
      w_pc_n       = redirect_pc_i;
      w_state_n    = ST_REQ;
      w_drop_n     = w_outstanding ||
                     (r_drop && !((r_state == ST_WAIT) && imem_rvalid_i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_id_valid <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_drop     <= w_drop_n;
      r_id_valid <= w_id_valid_n;
      r_buf_addr <= w_buf_addr_n;
      r_buf_data <= w_buf_data_n;
    end
  end

  assign imem_req_o  = (r_state == ST_REQ);
  assign imem_addr_o = r_pc;
  assign id_valid_o  = r_id_valid;
  assign reg_we_o    = w_we;
  assign reg_addr_o  = w_waddr;
  assign reg_data_o  = w_wdata;

`ifdef IF_ID_PERF_CNT_EN
  if_id_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_fetch     (w_real_wr),
    .i_stall     (r_state == ST_HOLD),
    .i_drop      (w_discard),
    .o_fetch_cnt (fetch_cnt_o),
    .o_stall_cnt (stall_cnt_o),
    .o_drop_cnt  (drop_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// tb/tb_if_id_ctrl.sv - directed self-checking bench for if_id_ctrl
module tb_if_id_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic        reg_we_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_data_o;

  int checks;
  int failures;

  if_id_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .id_ready_i       (id_ready_i),
    .id_valid_o       (id_valid_o),
    .reg_we_o         (reg_we_o),
    .reg_addr_o       (reg_addr_o),
    .reg_data_o       (reg_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
    tick(); tick(); #1;
    checks++; if ({imem_req_o, reg_we_o, id_valid_o} !== 3'b000) begin failures++;
      $display("FAIL reset_ctl req/we/valid=%b want 000", {imem_req_o, reg_we_o, id_valid_o}); end
    checks++; if (reg_addr_o !== 32'h0) begin failures++; $display("FAIL reset_raddr got %h want 0", reg_addr_o); end
    checks++; if (reg_data_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", reg_data_o); end
    checks++; if (imem_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got %h want 80000000", imem_addr_o); end
    rst = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL idle_req got %b want 0", imem_req_o); end
    tick();
  endtask

  task automatic test_basic_fetch();
    #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8000_0000}) begin failures++;
      $display("FAIL basic_req got %b/%h want 1/80000000", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0; #1;
    checks++; if ({imem_req_o, reg_we_o} !== 2'b00) begin failures++; $display("FAIL basic_wait req/we=%b want 00", {imem_req_o, reg_we_o}); end
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0113; id_ready_i = 1'b1; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h8000_0000, 32'h0000_0113}) begin failures++;
      $display("FAIL basic_write got %b/%h/%h want 1/80000000/00000113", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); imem_rvalid_i = 1'b0; id_ready_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_req_o, reg_we_o, imem_addr_o} !== {3'b110, 32'h8000_0004}) begin failures++;
      $display("FAIL basic_next got v=%b req=%b we=%b addr=%h want 1/1/0/80000004", id_valid_o, imem_req_o, reg_we_o, imem_addr_o); end
  endtask

  task automatic test_hold();
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0093; #1;
    checks++; if (reg_we_o !== 1'b0) begin failures++; $display("FAIL hold_nowrite got we=%b want 0", reg_we_o); end
    tick(); imem_rvalid_i = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({imem_req_o, reg_we_o, id_valid_o} !== 3'b001) begin failures++;
        $display("FAIL hold_state[%0d] req/we/valid=%b want 001", i, {imem_req_o, reg_we_o, id_valid_o}); end
      if (i == 0) tick();
    end
    id_ready_i = 1'b1; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h8000_0004, 32'h0000_0093}) begin failures++;
      $display("FAIL hold_release got %b/%h/%h want 1/80000004/00000093", reg_we_o, reg_addr_o, reg_data_o); end
    tick();
    checks++; if ({id_valid_o, reg_we_o, imem_addr_o} !== {2'b10, 32'h8000_0008}) begin failures++;
      $display("FAIL hold_after got v=%b we=%b addr=%h want 1/0/80000008", id_valid_o, reg_we_o, imem_addr_o); end
    tick(); id_ready_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_req_o} !== 2'b01) begin failures++;
      $display("FAIL consume got v/req=%b want 01", {id_valid_o, imem_req_o}); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0100; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h0, 32'h0000_0013}) begin failures++;
      $display("FAIL rdw_flush got %b/%h/%h want 1/00000000/00000013", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); redirect_valid_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h8000_0100}) begin failures++;
      $display("FAIL rdw_next got v=%b req=%b addr=%h want 0/1/80000100", id_valid_o, imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; id_ready_i = 1'b1; #1;
    checks++; if (reg_we_o !== 1'b0) begin failures++; $display("FAIL rdw_stale got we=%b want 0", reg_we_o); end
    tick(); imem_rvalid_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h8000_0100}) begin failures++;
      $display("FAIL rdw_refetch got v=%b req=%b addr=%h want 0/1/80000100", id_valid_o, imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h8000_0100, 32'h0050_0093}) begin failures++;
      $display("FAIL rdw_write got %b/%h/%h want 1/80000100/00500093", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); imem_rvalid_i = 1'b0; id_ready_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_addr_o} !== {1'b1, 32'h8000_0104}) begin failures++;
      $display("FAIL rdw_after got v=%b addr=%h want 1/80000104", id_valid_o, imem_addr_o); end
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0111;
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0200; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h0, 32'h0000_0013}) begin failures++;
      $display("FAIL rdr_flush got %b/%h/%h want 1/00000000/00000013", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); imem_rvalid_i = 1'b0; redirect_valid_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h8000_0200}) begin failures++;
      $display("FAIL rdr_next got v=%b req=%b addr=%h want 0/1/80000200", id_valid_o, imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0222; id_ready_i = 1'b1; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h8000_0200, 32'h0000_0222}) begin failures++;
      $display("FAIL rdr_nodrop got %b/%h/%h want 1/80000200/00000222", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); imem_rvalid_i = 1'b0; id_ready_i = 1'b0; #1;
    checks++; if ({id_valid_o, imem_addr_o} !== {1'b1, 32'h8000_0204}) begin failures++;
      $display("FAIL rdr_after got v=%b addr=%h want 1/80000204", id_valid_o, imem_addr_o); end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8000_0204}) begin failures++;
        $display("FAIL gnt_stall[%0d] got req=%b addr=%h want 1/80000204", i, imem_req_o, imem_addr_o); end
      tick();
    end
    imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    rst = 1'b1; tick(); #1;
    checks++; if ({imem_req_o, reg_we_o, id_valid_o, reg_addr_o, reg_data_o} !== 67'h0) begin failures++;
      $display("FAIL rstw_outs req=%b we=%b v=%b ra=%h rd=%h want all 0", imem_req_o, reg_we_o, id_valid_o, reg_addr_o, reg_data_o); end
    rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0333; id_ready_i = 1'b1; #1;
    checks++; if (reg_we_o !== 1'b0) begin failures++; $display("FAIL rstw_late_idle got we=%b want 0", reg_we_o); end
    tick(); #1;
    checks++; if ({imem_req_o, reg_we_o, imem_addr_o} !== {2'b10, 32'h8000_0000}) begin failures++;
      $display("FAIL rstw_restart got req=%b we=%b addr=%h want 1/0/80000000", imem_req_o, reg_we_o, imem_addr_o); end
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0444; #1;
    checks++; if ({reg_we_o, reg_addr_o, reg_data_o} !== {1'b1, 32'h8000_0000, 32'h0000_0444}) begin failures++;
      $display("FAIL rstw_write got %b/%h/%h want 1/80000000/00000444", reg_we_o, reg_addr_o, reg_data_o); end
    tick(); imem_rvalid_i = 1'b0; id_ready_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_fetch();
    test_hold();
    test_redirect_wait();
    test_redirect_rvalid();
    test_gnt_stall();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Fetch sequencer and controller for the IF/ID pipeline register.
- Owns the fetch PC and issues one-outstanding requests to the instruction memory port.
- Drives the IF/ID register's write enable, address input and data input, and tracks its valid bit.
- Handles backpressure from decode, and redirects from execute by dropping in-flight responses and flushing the register with a NOP.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- NOP_INST, 32'h0000_0013, instruction written into IF/ID on flush.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid_i  in  1  EXU redirect request.
- redirect_pc_i  in  ADDR_W  redirect target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  ADDR_W  fetch address; equals pc_q.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  DATA_W  response instruction.
- id_ready_i  in  1  decode consumes the IF/ID contents this cycle.
- id_valid_o  out  1  IF/ID register holds a live instruction.
- reg_we_o  out  1  IF/ID register write enable.
- reg_addr_o  out  ADDR_W  IF/ID register address input.
- reg_data_o  out  DATA_W  IF/ID register data input.

Behaviour:
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC, state=IDLE, drop_q=0, buf_q=0.
  - Outputs: id_valid_o=0, imem_req_o=0, reg_we_o=0, reg_addr_o=0, reg_data_o=0.
  - Reset mid-transaction abandons it. Any later rvalid for that transaction arrives while drop_q=0 and state is not WAIT, so it is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: exists for one cycle after reset, then moves to REQ.
  - REQ: imem_req_o=1 while in REQ. On gnt, move to WAIT. The request stays asserted with a stable address until gnt.
  - WAIT: imem_req_o=0. Wait for rvalid.
    - On rvalid with drop_q=1: discard the response, clear drop_q, go to REQ.
    - If slot free (id_valid_o=0 or id_ready_i=1): reg_we_o=1 combinationally that cycle, reg_addr_o=pc_q, reg_data_o=imem_rdata_i. Next edge: id_valid_o=1, pc_q+=4, go to REQ.
    - Else: capture addr/data into buf_q, pc_q+=4, go to HOLD.
  - HOLD: imem_req_o=0.
    - When id_ready_i=1: reg_we_o=1 with the buf_q contents, id_valid_o stays 1, go to REQ.
- Consumption without a write: id_ready_i=1 with id_valid_o=1 and reg_we_o=0 clears id_valid_o at the next edge.
- Write-back-to-back: rvalid and id_ready_i in the same cycle means the new instruction is written and id_valid_o stays 1. Zero bubble.
- Redirect (redirect_valid_i=1) has top priority in every state, including the same cycle as rvalid or gnt:
  - Flush the register in that cycle: reg_we_o=1, reg_data_o=NOP_INST, reg_addr_o=0.
  - Next edge: id_valid_o=0, pc_q=redirect_pc_i, buf_q discarded, state=REQ.
  - drop_q is set if a request is outstanding: state WAIT, or REQ with gnt this cycle. A response arriving in the redirect cycle itself counts as consumed, not dropped.
- Redirect target is used as given (bits [1:0] unchecked). pc_q wraps modulo 2^ADDR_W.
- At most one outstanding imem transaction at any time.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds ports:
  - fetch_cnt_o (out, 32): counts writes of real instructions into IF/ID.
  - stall_cnt_o (out, 32): counts cycles in HOLD.
  - drop_cnt_o (out, 32): counts discarded responses.
- All three counters reset to 0, saturate at 32'hFFFF_FFFF, and do not count the NOP flush.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines: FSM state encoding, RESET_PC default, NOP_INST, ADDR_W/DATA_W widths.
- The IF/ID register itself stays a separate existing block and is driven by reg_we_o/reg_addr_o/reg_data_o.
- Sub-module: if_id_perf_cnt (saturating counter triple), instantiated only under IF_ID_PERF_CNT_EN.

Test Plan:
- Reset release, gnt immediate, rvalid 2 cycles later, id_ready_i=1 -> imem_addr_o=8000_0000; reg_we_o pulses with reg_addr_o=8000_0000; next request at 8000_0004.
- id_ready_i=0 while id_valid_o=1, rvalid with 0000_0093 -> HOLD, imem_req_o=0, no write. Raising id_ready_i -> reg_we_o=1, reg_data_o=0000_0093.
- Redirect to 8000_0100 while in WAIT -> NOP written, id_valid_o=0 next cycle. Stale rvalid is ignored. Next imem_addr_o=8000_0100.
- Redirect in the same cycle as rvalid -> flush wins, reg_data_o=0000_0013. No drop pending; next request at the redirect target.
- gnt held low 5 cycles -> imem_req_o and imem_addr_o stable for all 5 cycles.
- rst asserted in WAIT -> all outputs 0 next edge. Late rvalid ignored. Fetch restarts at 8000_0000.
